sdrstick_rx_arbiter: RTL and testbench
======================================

SDRSTICK_RX_ARBITER -- requirements
Module: sdrstick_rx_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of receiver channels sharing one FIFO write port (supported range 2..4).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_strobe  input  NUM_CH  one-cycle sample-valid pulse per channel.
REQ-005 SHALL have port rx_i  input  24*NUM_CH  packed signed I samples; channel n occupies bits [24n+23:24n].
REQ-006 SHALL have port rx_q  input  24*NUM_CH  packed signed Q samples, same packing as rx_i.
REQ-007 SHALL have port fifo_full  input  1  FIFO cannot accept a word this cycle.
REQ-008 SHALL have port fifo_write  output  1  word on fifo_writedata accepted this cycle.
REQ-009 SHALL have port fifo_writedata  output  32  tagged sample word.
REQ-010 SHALL have ports ctl_address  input  3, ctl_read  input  1, ctl_write  input  1, ctl_writedata  input  32, ctl_readdata  output  32, forming the CPU register interface.

Function
REQ-011 SHALL hold, per channel, a pending flag and 24-bit I/Q holding registers.
REQ-012 SHALL, on rx_strobe[n] with enable[n]=1, capture rx_i/rx_q for channel n and set pending[n] on the next edge; strobes on disabled channels are ignored.
REQ-013 SHALL treat a strobe on a channel whose pending flag is set and not granted that cycle as overrun: new data overwrites old, overrun[n] set, overrun counter incremented.
REQ-014 SHALL treat a strobe in the same cycle its channel is granted as a fresh sample (pending stays set, no overrun).
REQ-015 SHALL use states IDLE, WRITE_I, WRITE_Q; unused encodings return to IDLE.
REQ-016 IDLE: if any pending, grant the first pending channel after last_grant (round-robin, wrapping NUM_CH-1 -> 0), copy its I/Q to output registers, clear its pending, update last_grant, go WRITE_I; otherwise stay.
REQ-017 WRITE_I: fifo_writedata = {ch[1:0], 1'b0, 5'b0, I[23:0]}; fifo_write = !fifo_full; advance to WRITE_Q only in a cycle with fifo_write=1.
REQ-018 WRITE_Q: fifo_writedata = {ch[1:0], 1'b1, 5'b0, Q[23:0]}; fifo_write = !fifo_full; advance to IDLE only in a cycle with fifo_write=1.
REQ-019 fifo_write SHALL be 0 in IDLE; fifo_write/fifo_writedata decode from registered state and data only (no path from rx_* inputs).
REQ-020 Latency: strobe at cycle 0 with FIFO not full and arbiter idle -> I word written cycle 2, Q word cycle 3; channel service rate one pair per 3 cycles.
REQ-021 I and Q of a pair SHALL always be written back-to-back with no other channel's word between them.
REQ-022 Clearing enable[n] SHALL clear pending[n] on the next edge; a pair already granted SHALL complete.
REQ-023 Register 0 (RW): enable[NUM_CH-1:0], upper bits read 0.
REQ-024 Register 1: overrun[NUM_CH-1:0] sticky; write-1-to-clear; a set event coincident with a clear leaves the bit set.
REQ-025 Register 2: 16-bit overrun counter, saturates at 0xFFFF; any write clears it; coincident increment and clear yields 1 when increment is present, else 0.
REQ-026 Register 3 (RO): {state[1:0] in bits 17:16, pending[NUM_CH-1:0] in bits 3:0}; other addresses read 0.
REQ-027 ctl_readdata SHALL update one cycle after ctl_read and hold otherwise; writes to RO addresses are ignored.
REQ-028 Simultaneous strobes on several enabled channels SHALL all be captured; service order follows REQ-016.

Reset
REQ-029 Reset SHALL asynchronously force state=IDLE, pending=0, enable=0, overrun=0, counter=0, last_grant=NUM_CH-1, ctl_readdata=0, fifo_write=0, output data registers 0.
REQ-030 Reset mid-pair SHALL abort the pair; no further fifo_write until a new strobe after reset release and enable.

Verification
REQ-031 enable=0xF, strobe ch2 I=0x123456 Q=0xABCDEF, fifo_full=0 -> cycle 2 write 0x80123456, cycle 3 write 0xA0ABCDEF.
REQ-032 enable=0xF, strobe all four simultaneously after reset -> words ordered ch0 I,Q, ch1, ch2, ch3; 8 writes over 12 cycles.
REQ-033 fifo_full=1 during WRITE_I for 5 cycles -> fifo_write stays 0, data stable; releases, then I then Q written once each.
REQ-034 Two strobes on ch1 before grant (fifo_full held) -> overrun=0x2, counter=1, only second sample written; write 0x2 to reg 1 -> reads 0.
REQ-035 enable=0x1, strobe ch3 -> no write; assert reset during WRITE_Q -> fifo_write=0 immediately, all registers read 0.

Source files
------------

// File: rtl/sdrstick_rx_arbiter.sv
// ============================================================================
// Module  : sdrstick_rx_arbiter
// Brief   : Round-robin arbiter merging per-channel I/Q samples into one
//           tagged 32-bit FIFO write stream, with a small CPU register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdrstick_rx_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     rx_strobe,
  input  logic [24*NUM_CH-1:0]  rx_i,
  input  logic [24*NUM_CH-1:0]  rx_q,
  input  logic                  fifo_full,
  output logic                  fifo_write,
  output logic [31:0]           fifo_writedata,
  input  logic [2:0]            ctl_address,
  input  logic                  ctl_read,
  input  logic                  ctl_write,
  input  logic [31:0]           ctl_writedata,
  output logic [31:0]           ctl_readdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE_I = 2'd1,
    WRITE_Q = 2'd2
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] overrun;
  logic [15:0]       ovr_count;
  logic [1:0]        last_grant;
  logic [1:0]        out_ch;
  logic [23:0]       out_i;
  logic [23:0]       out_q;
  logic [23:0]       hold_i [NUM_CH];
  logic [23:0]       hold_q [NUM_CH];

  logic [3:0]        eligible;
  logic              grant_valid;
  logic [1:0]        grant_ch;
  logic [2:0]        idx;
  logic [NUM_CH-1:0] grant_vec;
  logic [NUM_CH-1:0] capture;
  logic [NUM_CH-1:0] ovr_evt;
  logic [NUM_CH-1:0] ovr_clr;
  logic              unused_wdata;

  assign unused_wdata = ^ctl_writedata[31:NUM_CH];

  // Scan downward so the channel closest after last_grant wins.
  always_comb begin
    eligible    = 4'(pending & enable);
    grant_valid = 1'b0;
    grant_ch    = 2'd0;
    idx         = 3'd0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = {1'b0, last_grant} + 3'(i);
      if (idx >= 3'(NUM_CH)) idx = idx - 3'(NUM_CH);
      if (eligible[idx[1:0]]) begin
        grant_valid = 1'b1;
        grant_ch    = idx[1:0];
      end
    end
  end

  generate
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      assign grant_vec[n] = (state == IDLE) && grant_valid && (grant_ch == 2'(n));
      assign capture[n]   = rx_strobe[n] & enable[n];
      assign ovr_evt[n]   = capture[n] & pending[n] & ~grant_vec[n];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pending[n] <= 1'b0;
          hold_i[n]  <= 24'd0;
          hold_q[n]  <= 24'd0;
        end else if (!enable[n]) begin
          pending[n] <= 1'b0;
        end else if (capture[n]) begin
          pending[n] <= 1'b1;
          hold_i[n]  <= rx_i[24*n +: 24];
          hold_q[n]  <= rx_q[24*n +: 24];
        end else if (grant_vec[n]) begin
          pending[n] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 2'(NUM_CH - 1);
      out_ch     <= 2'd0;
      out_i      <= 24'd0;
      out_q      <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            out_ch     <= grant_ch;
            out_i      <= hold_i[grant_ch];
            out_q      <= hold_q[grant_ch];
            last_grant <= grant_ch;
            state      <= WRITE_I;
          end
        end
        WRITE_I: if (!fifo_full) state <= WRITE_Q;
        WRITE_Q: if (!fifo_full) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_write     = ((state == WRITE_I) || (state == WRITE_Q)) && !fifo_full;
  assign fifo_writedata = {out_ch, (state == WRITE_Q), 5'b0,
                           (state == WRITE_Q) ? out_q : out_i};

  assign ovr_clr = (ctl_write && ctl_address == 3'd1) ? ctl_writedata[NUM_CH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable       <= '0;
      overrun      <= '0;
      ovr_count    <= 16'd0;
      ctl_readdata <= 32'd0;
    end else begin
      if (ctl_write && ctl_address == 3'd0) enable <= ctl_writedata[NUM_CH-1:0];
      overrun <= (overrun & ~ovr_clr) | ovr_evt;
      if (ctl_write && ctl_address == 3'd2)
        ovr_count <= {15'd0, |ovr_evt};
      else if (|ovr_evt && ovr_count != 16'hFFFF)
        ovr_count <= ovr_count + 16'd1;
      if (ctl_read) begin
        case (ctl_address)
          3'd0:    ctl_readdata <= 32'(enable);
          3'd1:    ctl_readdata <= 32'(overrun);
          3'd2:    ctl_readdata <= {16'd0, ovr_count};
          3'd3:    ctl_readdata <= {14'd0, state, 12'd0, 4'(pending)};
          default: ctl_readdata <= 32'd0;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdrstick_rx_arbiter.sv
// ============================================================================
// Module  : tb_sdrstick_rx_arbiter
// Brief   : Scoreboard bench for sdrstick_rx_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sdrstick_rx_arbiter;
  localparam int NUM_CH = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_CH-1:0]    rx_strobe = '0;
  logic [24*NUM_CH-1:0] rx_i = '0;
  logic [24*NUM_CH-1:0] rx_q = '0;
  logic                 fifo_full = 1'b0;
  logic                 fifo_write;
  logic [31:0]          fifo_writedata;
  logic [2:0]           ctl_address = 3'd0;
  logic                 ctl_read = 1'b0;
  logic                 ctl_write = 1'b0;
  logic [31:0]          ctl_writedata = 32'd0;
  logic [31:0]          ctl_readdata;

  sdrstick_rx_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset), .rx_strobe(rx_strobe), .rx_i(rx_i), .rx_q(rx_q),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_writedata(fifo_writedata),
    .ctl_address(ctl_address), .ctl_read(ctl_read), .ctl_write(ctl_write),
    .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  word_t mon_w;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && fifo_write) begin
      mon_w.data = fifo_writedata;
      mon_w.cyc  = cyc;
      obs_q.push_back(mon_w);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_strobe = '0; fifo_full = 1'b0; ctl_read = 1'b0; ctl_write = 1'b0;
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    ctl_address = a; ctl_writedata = d; ctl_write = 1'b1;
    tick(1);
    ctl_write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    ctl_address = a; ctl_read = 1'b1;
    tick(1);
    ctl_read = 1'b0;
    d = ctl_readdata;
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [95:0] iv, input logic [95:0] qv,
                        output int c0);
    rx_strobe = mask; rx_i = iv; rx_q = qv; c0 = cyc;
    tick(1);
    rx_strobe = '0;
  endtask

  task automatic push_exp(input logic [31:0] d, input int c);
    word_t w;
    w.data = d; w.cyc = c;
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    tick(2);
    n_checks++;
    if (fifo_write !== 1'b0 || fifo_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: write=%b data=%h, expected 0/00000000", fifo_write, fifo_writedata);
    end
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      reg_read(3'(a), rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, expected 00000000", a, rd);
      end
    end
  endtask

  task automatic test_single();
    int c0;
    word_t e, o;
    do_reset();
    reg_write(3'd0, 32'hF);
    strobe(4'b0100, {24'h0, 24'h123456, 48'h0}, {24'h0, 24'hABCDEF, 48'h0}, c0);
    push_exp(32'h80123456, c0 + 2);
    push_exp(32'hA0ABCDEF, c0 + 3);
    tick(6);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL single_word: none written, expected %h at cycle %0d", e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL single_word: got %h at cycle %0d, expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL single_extra: %0d extra writes, expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_all_four();
    int c0;
    logic [95:0] ib, qb;
    logic [23:0] iv, qv;
    logic [31:0] rd;
    word_t e, o;
    do_reset();
    reg_write(3'd0, 32'hF);
    for (int n = 0; n < 4; n++) begin
      ib[24*n +: 24] = {4'(n + 1), 20'h12345};
      qb[24*n +: 24] = {4'(n + 8), 20'hABCDE};
    end
    strobe(4'hF, ib, qb, c0);
    for (int n = 0; n < 4; n++) begin
      iv = {4'(n + 1), 20'h12345};
      qv = {4'(n + 8), 20'hABCDE};
      push_exp({2'(n), 1'b0, 5'b0, iv}, c0 + 2 + 3 * n);
      push_exp({2'(n), 1'b1, 5'b0, qv}, c0 + 3 + 3 * n);
    end
    tick(16);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL all_four_word: none written, expected %h at cycle %0d", e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL all_four_word: got %h at cycle %0d, expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL all_four_extra: %0d extra writes, expected 0", obs_q.size()); obs_q.delete();
    end
    reg_read(3'd2, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL all_four_counter: got %h, expected 00000000", rd);
    end
  endtask

  task automatic test_backpressure();
    int c0;
    word_t e, o;
    fifo_full = 1'b1;
    strobe(4'b0010, {48'h0, 24'h654321, 24'h0}, {48'h0, 24'h0FEDCB, 24'h0}, c0);
    tick(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_write !== 1'b0 || fifo_writedata !== 32'h40654321) begin
        n_fail++;
        $display("FAIL stall_hold: write=%b data=%h, expected 0/40654321", fifo_write, fifo_writedata);
      end
      tick(1);
    end
    fifo_full = 1'b0;
    push_exp(32'h40654321, c0 + 7);
    push_exp(32'h600FEDCB, c0 + 8);
    tick(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL stall_word: none written, expected %h at cycle %0d", e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL stall_word: got %h at cycle %0d, expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL stall_extra: %0d extra writes, expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_overrun();
    int c0;
    logic [31:0] rd;
    word_t e, o;
    fifo_full = 1'b1;
    strobe(4'b0001, {72'h0, 24'h000AAA}, {72'h0, 24'h000BBB}, c0);
    strobe(4'b0010, {48'h0, 24'h00A0A0, 24'h0}, {48'h0, 24'h00A1A1, 24'h0}, c0);
    strobe(4'b0010, {48'h0, 24'h00B0B0, 24'h0}, {48'h0, 24'h00C0C0, 24'h0}, c0);
    tick(2);
    reg_read(3'd1, rd);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL overrun_flag: got %h, expected 00000002", rd); end
    reg_read(3'd2, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL overrun_count: got %h, expected 00000001", rd); end
    reg_read(3'd3, rd);
    n_checks++;
    if (rd !== 32'h00010002) begin n_fail++; $display("FAIL overrun_status: got %h, expected 00010002", rd); end
    push_exp(32'h00000AAA, -1);
    push_exp(32'h20000BBB, -1);
    push_exp(32'h4000B0B0, -1);
    push_exp(32'h6000C0C0, -1);
    fifo_full = 1'b0;
    tick(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL overrun_word: none written, expected %h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data) begin
          n_fail++; $display("FAIL overrun_word: got %h, expected %h", o.data, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL overrun_extra: %0d extra writes, expected 0", obs_q.size()); obs_q.delete();
    end
    reg_write(3'd1, 32'h2);
    reg_read(3'd1, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL overrun_w1c: got %h, expected 00000000", rd); end
    reg_write(3'd2, 32'h0);
    reg_read(3'd2, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL count_clear: got %h, expected 00000000", rd); end
  endtask

  task automatic test_enable_reset();
    int c0;
    logic [31:0] rd;
    word_t e, o;
    reg_write(3'd0, 32'h1);
    strobe(4'b1000, {24'h777777, 72'h0}, {24'h888888, 72'h0}, c0);
    tick(6);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL disabled_ch: %0d writes, expected 0", obs_q.size()); obs_q.delete();
    end
    strobe(4'b0001, {72'h0, 24'h111111}, {72'h0, 24'h222222}, c0);
    push_exp(32'h00111111, c0 + 2);
    tick(2);
    n_checks++;
    if (fifo_write !== 1'b1 || fifo_writedata !== 32'h20222222) begin
      n_fail++;
      $display("FAIL mid_pair: write=%b data=%h, expected 1/20222222", fifo_write, fifo_writedata);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (fifo_write !== 1'b0 || fifo_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: write=%b data=%h, expected 0/00000000", fifo_write, fifo_writedata);
    end
    tick(2);
    reset = 1'b0;
    tick(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL abort_word: none written, expected %h at cycle %0d", e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL abort_word: got %h at cycle %0d, expected %h at cycle %0d", o.data, o.cyc, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL abort_extra: %0d writes after reset, expected 0", obs_q.size()); obs_q.delete();
    end
    for (int a = 0; a < 4; a++) begin
      reg_read(3'(a), rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++; $display("FAIL post_reset_reg%0d: got %h, expected 00000000", a, rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_overrun();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
